carry_skip_pipe_adder: RTL and testbench

Parametrised, pipelined carry-skip adder/subtractor. It generalises the fixed 16-bit, 4-bit-block carry-skip adder to any width and block size. It adds a subtract mode, signed overflow, a per-block skip report, and pipeline registers with valid/ready backpressure. It sits in the datapath wherever a wide add or subtract must close timing at full clock rate and tolerate a stalling consumer.

---
 rtl/carry_skip_pipe_adder_if.sv | 41 ++++
 rtl/carry_skip_pipe_adder.sv | 186 ++++++++++++++++++
 tb/tb_carry_skip_pipe_adder.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/carry_skip_pipe_adder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : carry_skip_pipe_adder_if                                        |
// | Purpose  : Operand/result bus of the pipelined carry-skip adder.           |
// |            Input side: in_valid/in_ready handshake, a, b, cin, sub.        |
// |            Output side: out_valid/out_ready handshake, sum, cout, ovf,     |
// |            skip_mask (one bit per BLK-bit carry-skip block).               |
// |            slave  = the adder, master = whoever drives operands and        |
// |            consumes results.                                               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface carry_skip_pipe_adder_if #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) ();
  localparam int NBLK = WIDTH / BLK;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic [NBLK-1:0]  skip_mask;

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, skip_mask
  );

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, skip_mask
  );
endinterface
`default_nettype wire

// File: rtl/carry_skip_pipe_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : carry_skip_pipe_adder                                           |
// | Purpose  : Pipelined carry-skip adder/subtractor with valid/ready flow     |
// |            control. SPS carry-skip blocks of BLK bits are evaluated per    |
// |            stage, giving LAT = WIDTH/BLK/SPS register stages.              |
// | Ports    : clk  - rising-edge clock                                        |
// |            rst  - synchronous active-high reset                            |
// |            bus  - slave side of carry_skip_pipe_adder_if (operands in,     |
// |                   sum/cout/ovf/skip_mask out, global-stall handshake)      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module carry_skip_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4,
  parameter int SPS   = 2
) (
  input logic                    clk,
  input logic                    rst,
  carry_skip_pipe_adder_if.slave bus
);
  localparam int NBLK = WIDTH / BLK;
  localparam int LAT  = NBLK / SPS;
  localparam int SW   = SPS * BLK;   // operand bits consumed per stage

  typedef struct packed {
    logic [SW-1:0]  sum;
    logic [SPS-1:0] skip;
    logic           cout;
  } stage_res_t;

  // One stage worth of carry-skip blocks. Inside a block the sum ripples;
  // the block carry-out bypasses the ripple whenever all propagates are set.
  function automatic stage_res_t eval_stage(input logic [SW-1:0] a_s,
                                            input logic [SW-1:0] bb_s,
                                            input logic          c_s);
    stage_res_t r;
    logic       c;
    logic       rc;
    logic       prop;
    logic       p;
    r = '0;
    c = c_s;
    for (int j = 0; j < SPS; j++) begin
      rc   = c;
      prop = 1'b1;
      for (int t = 0; t < BLK; t++) begin
        p                = a_s[j*BLK+t] ^ bb_s[j*BLK+t];
        r.sum[j*BLK+t]   = p ^ rc;
        rc               = (a_s[j*BLK+t] & bb_s[j*BLK+t]) | (p & rc);
        prop             = prop & p;
      end
      r.skip[j] = prop;
      c         = prop ? c : rc;
    end
    r.cout = c;
    return r;
  endfunction

  // Global stall: every register advances together or holds together.
  logic advance;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [NBLK-1:0]  skip_q, skip_d;

  assign advance       = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.skip_mask = skip_q;

  for (genvar k = 0; k < LAT; k++) begin : g_stage
    localparam int DONE = k * SW;          // result bits finished upstream
    localparam int REM  = WIDTH - DONE;    // operand bits still to add

    logic [REM-1:0]       a_in;
    logic [REM-1:0]       bb_in;
    logic                 c_in;
    logic                 v_in;
    logic [DONE+SW-1:0]   sum_acc;
    logic [(k+1)*SPS-1:0] skip_acc;
    stage_res_t           res;

    assign res = eval_stage(a_in[SW-1:0], bb_in[SW-1:0], c_in);

    if (k == 0) begin : g_head
      // Subtract is a + ~b + 1; the borrow-in flips the carry-in.
      assign a_in     = bus.a;
      assign bb_in    = bus.b ^ {WIDTH{bus.sub}};
      assign c_in     = bus.cin ^ bus.sub;
      assign v_in     = bus.in_valid;
      assign sum_acc  = res.sum;
      assign skip_acc = res.skip;
    end else begin : g_tail
      assign a_in     = g_stage[k-1].g_reg.a_q;
      assign bb_in    = g_stage[k-1].g_reg.bb_q;
      assign c_in     = g_stage[k-1].g_reg.c_q;
      assign v_in     = g_stage[k-1].g_reg.valid_q;
      assign sum_acc  = {res.sum, g_stage[k-1].g_reg.sum_q};
      assign skip_acc = {res.skip, g_stage[k-1].g_reg.skip_q};
    end

    if (k < LAT - 1) begin : g_reg
      logic                 valid_q, valid_d;
      logic                 c_q, c_d;
      logic [DONE+SW-1:0]   sum_q, sum_d;
      logic [(k+1)*SPS-1:0] skip_q, skip_d;
      // Only the not-yet-added operand bits travel on down the pipe.
      logic [REM-SW-1:0]    a_q, a_d;
      logic [REM-SW-1:0]    bb_q, bb_d;

      always_comb begin
        valid_d = valid_q;
        c_d     = c_q;
        sum_d   = sum_q;
        skip_d  = skip_q;
        a_d     = a_q;
        bb_d    = bb_q;
        if (advance) begin
          valid_d = v_in;
          c_d     = res.cout;
          sum_d   = sum_acc;
          skip_d  = skip_acc;
          a_d     = a_in[REM-1:SW];
          bb_d    = bb_in[REM-1:SW];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_q <= 1'b0;
          c_q     <= 1'b0;
          sum_q   <= '0;
          skip_q  <= '0;
          a_q     <= '0;
          bb_q    <= '0;
        end else begin
          valid_q <= valid_d;
          c_q     <= c_d;
          sum_q   <= sum_d;
          skip_q  <= skip_d;
          a_q     <= a_d;
          bb_q    <= bb_d;
        end
      end
    end else begin : g_out
      always_comb begin
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        skip_d      = skip_q;
        if (advance) begin
          out_valid_d = v_in;
          sum_d       = sum_acc;
          cout_d      = res.cout;
          // Carry into the MSB is recovered as a ^ bb ^ sum at that bit.
          ovf_d       = a_in[SW-1] ^ bb_in[SW-1] ^ res.sum[SW-1] ^ res.cout;
          skip_d      = skip_acc;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid_q <= 1'b0;
          sum_q       <= '0;
          cout_q      <= 1'b0;
          ovf_q       <= 1'b0;
          skip_q      <= '0;
        end else begin
          out_valid_q <= out_valid_d;
          sum_q       <= sum_d;
          cout_q      <= cout_d;
          ovf_q       <= ovf_d;
          skip_q      <= skip_d;
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_carry_skip_pipe_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_carry_skip_pipe_adder                                        |
// | Purpose  : Self-checking bench for carry_skip_pipe_adder. Two instances:   |
// |            16/4/2 (LAT=2) for directed vectors and backpressure, and       |
// |            32/8/1 (LAT=4) for reset flush and a long random run.           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_carry_skip_pipe_adder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  carry_skip_pipe_adder_if #(.WIDTH(16), .BLK(4)) if16 ();
  carry_skip_pipe_adder_if #(.WIDTH(32), .BLK(8)) if32 ();

  carry_skip_pipe_adder #(.WIDTH(16), .BLK(4), .SPS(2)) dut16 (
    .clk(clk), .rst(rst), .bus(if16)
  );
  carry_skip_pipe_adder #(.WIDTH(32), .BLK(8), .SPS(1)) dut32 (
    .clk(clk), .rst(rst), .bus(if32)
  );

  typedef struct {
    longint unsigned sum;
    bit              cout;
    bit              ovf;
    longint unsigned skip;
    int              adv;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t q16[$];
  exp_t q32[$];
  int   adv16 = 0;
  int   adv32 = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference: plain wide arithmetic, overflow from the carry into the MSB,
  // skip bit = block of a^bb is all ones.
  function automatic exp_t model(input int w, input int blk,
                                 input longint unsigned a, input longint unsigned b,
                                 input bit cin, input bit sub);
    exp_t e;
    longint unsigned mask, bb, tot, low, bm;
    bit c0, cmsb;
    mask  = (64'd1 << w) - 64'd1;
    bb    = (sub ? ~b : b) & mask;
    c0    = cin ^ sub;
    tot   = a + bb + 64'(c0);
    e.sum = tot & mask;
    e.cout = ((tot >> w) & 64'd1) != 0;
    low   = (a & (mask >> 1)) + (bb & (mask >> 1)) + 64'(c0);
    cmsb  = ((low >> (w - 1)) & 64'd1) != 0;
    e.ovf = cmsb ^ e.cout;
    e.skip = 0;
    for (int i = 0; i < w / blk; i++) begin
      bm = ((64'd1 << blk) - 64'd1) << (i * blk);
      if (((a ^ bb) & bm) == bm) e.skip |= (64'd1 << i);
    end
    e.adv = 0;
    return e;
  endfunction

  task automatic observe(input int id, input int w, input int blk, input int lat,
                         input logic iv, input logic ir, input logic ov, input logic ordy,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic sub,
                         input logic [63:0] sum, input logic cout, input logic ovf,
                         input logic [63:0] skip);
    exp_t  e;
    string tag;
    int    n;
    int    adv;
    tag = (id == 0) ? "w16" : "w32";
    n   = (id == 0) ? q16.size() : q32.size();
    adv = (id == 0) ? adv16 : adv32;
    chk({tag, "_in_ready"}, 64'(ir), 64'(!ov || ordy));
    if (ov) begin
      if (n == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_spurious_out: actual out_valid=1 required=0", tag);
      end else begin
        e = (id == 0) ? q16[0] : q32[0];
        chk({tag, "_sum"}, sum, e.sum);
        chk({tag, "_cout"}, 64'(cout), 64'(e.cout));
        chk({tag, "_ovf"}, 64'(ovf), 64'(e.ovf));
        chk({tag, "_skip"}, skip, e.skip);
        chk({tag, "_latency"}, 64'(adv - e.adv), 64'(lat));
        if (ordy) begin
          if (id == 0) void'(q16.pop_front()); else void'(q32.pop_front());
        end
      end
    end
    if (iv && ir) begin
      e = model(w, blk, a, b, cin, sub);
      e.adv = adv;
      if (id == 0) q16.push_back(e); else q32.push_back(e);
    end
    if (ir) begin
      if (id == 0) adv16++; else adv32++;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q16.delete();
      q32.delete();
    end else begin
      observe(0, 16, 4, 2, if16.in_valid, if16.in_ready, if16.out_valid, if16.out_ready,
              64'(if16.a), 64'(if16.b), if16.cin, if16.sub,
              64'(if16.sum), if16.cout, if16.ovf, 64'(if16.skip_mask));
      observe(1, 32, 8, 4, if32.in_valid, if32.in_ready, if32.out_valid, if32.out_ready,
              64'(if32.a), 64'(if32.b), if32.cin, if32.sub,
              64'(if32.sum), if32.cout, if32.ovf, 64'(if32.skip_mask));
    end
  end

  task automatic send16(input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub);
    int   guard;
    logic acc;
    if16.in_valid = 1'b1;
    if16.a = a;
    if16.b = b;
    if16.cin = cin;
    if16.sub = sub;
    guard = 0;
    do begin
      @(negedge clk);
      acc = if16.in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 50);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send16_timeout: actual not accepted required accepted");
    end
    if16.in_valid = 1'b0;
  endtask

  task automatic rand32();
    logic [31:0] a;
    a = $urandom;
    if32.a = a;
    case ($urandom_range(0, 4))
      0:       if32.b = ~a;
      1:       if32.b = ~a ^ (32'h1 << $urandom_range(0, 31));
      2:       if32.b = a;
      default: if32.b = $urandom;
    endcase
    if32.cin = 1'($urandom_range(0, 1));
    if32.sub = 1'($urandom_range(0, 1));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        e;
    int          sent;
    int          cyc;
    int          n;
    bit          need_new;
    logic [63:0] frozen;

    rst = 1'b1;
    if16.in_valid = 0; if16.a = 0; if16.b = 0; if16.cin = 0; if16.sub = 0; if16.out_ready = 1;
    if32.in_valid = 0; if32.a = 0; if32.b = 0; if32.cin = 0; if32.sub = 0; if32.out_ready = 1;

    // Model pins. For 00FF+0001, a^b = 00FE, so block 1 is all-propagate.
    e = model(16, 4, 64'h00FF, 64'h0001, 1'b0, 1'b0);
    chk("pin_add_sum", e.sum, 64'h0100);
    chk("pin_add_cout", 64'(e.cout), 64'd0);
    chk("pin_add_ovf", 64'(e.ovf), 64'd0);
    chk("pin_add_skip", e.skip, 64'b0010);
    e = model(16, 4, 64'hFFFF, 64'h0000, 1'b1, 1'b0);
    chk("pin_chain_sum", e.sum, 64'h0000);
    chk("pin_chain_cout", 64'(e.cout), 64'd1);
    chk("pin_chain_ovf", 64'(e.ovf), 64'd0);
    chk("pin_chain_skip", e.skip, 64'b1111);
    e = model(16, 4, 64'h8000, 64'h0001, 1'b0, 1'b1);
    chk("pin_subovf_sum", e.sum, 64'h7FFF);
    chk("pin_subovf_cout", 64'(e.cout), 64'd1);
    chk("pin_subovf_ovf", 64'(e.ovf), 64'd1);
    chk("pin_subovf_skip", e.skip, 64'b0110);
    e = model(16, 4, 64'h0003, 64'h0005, 1'b0, 1'b1);
    chk("pin_subneg_sum", e.sum, 64'hFFFE);
    chk("pin_subneg_cout", 64'(e.cout), 64'd0);
    chk("pin_subneg_ovf", 64'(e.ovf), 64'd0);
    chk("pin_subneg_skip", e.skip, 64'b1110);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid16", 64'(if16.out_valid), 64'd0);
    chk("rst_sum16", 64'(if16.sum), 64'd0);
    chk("rst_cout16", 64'(if16.cout), 64'd0);
    chk("rst_ovf16", 64'(if16.ovf), 64'd0);
    chk("rst_skip16", 64'(if16.skip_mask), 64'd0);
    chk("rst_in_ready16", 64'(if16.in_ready), 64'd1);
    chk("rst_out_valid32", 64'(if32.out_valid), 64'd0);
    chk("rst_sum32", 64'(if32.sum), 64'd0);
    @(posedge clk);
    #1;

    // Directed vectors, back to back.
    send16(16'h00FF, 16'h0001, 1'b0, 1'b0);
    send16(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    send16(16'h8000, 16'h0001, 1'b0, 1'b1);
    send16(16'h0003, 16'h0005, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    #1;

    // Backpressure: 6 beats, consumer stalls for cycles 3..5.
    sent = 0;
    need_new = 1'b1;
    frozen = '0;
    for (int c = 0; c < 20; c++) begin
      if16.out_ready = !(c >= 3 && c <= 5);
      if (sent < 6) begin
        if16.in_valid = 1'b1;
        if (need_new) begin
          if16.a = 16'($urandom);
          if16.b = 16'($urandom);
          if16.cin = 1'($urandom_range(0, 1));
          if16.sub = 1'($urandom_range(0, 1));
        end
      end else begin
        if16.in_valid = 1'b0;
      end
      @(negedge clk);
      if (c >= 3 && c <= 5) chk("bp_in_ready", 64'(if16.in_ready), 64'd0);
      if (c == 3) frozen = 64'({if16.sum, if16.cout, if16.ovf, if16.skip_mask});
      if (c == 4 || c == 5)
        chk("bp_frozen", 64'({if16.sum, if16.cout, if16.ovf, if16.skip_mask}), frozen);
      need_new = if16.in_valid && if16.in_ready;
      if (need_new) sent++;
      @(posedge clk);
      #1;
    end
    if16.in_valid = 1'b0;
    if16.out_ready = 1'b1;
    chk("bp_sent", 64'(sent), 64'd6);
    chk("bp_drain16", 64'(q16.size()), 64'd0);

    // Reset mid-flight on the LAT=4 instance.
    for (int i = 0; i < 2; i++) begin
      rand32();
      if32.in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    if32.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rstflush_out_valid", 64'(if32.out_valid), 64'd0);
      chk("rstflush_in_ready", 64'(if32.in_ready), 64'd1);
    end
    @(posedge clk);
    #1;
    rand32();
    if32.in_valid = 1'b1;
    @(negedge clk);
    chk("post_rst_accept", 64'(if32.in_ready), 64'd1);
    @(posedge clk);
    #1;
    if32.in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if32.out_valid && n < 20);
    chk("post_rst_latency", 64'(n), 64'd4);
    @(posedge clk);
    #1;

    // Long random run with random backpressure.
    sent = 0;
    cyc = 0;
    need_new = 1'b1;
    while (sent < 10000 && cyc < 60000) begin
      if32.out_ready = ($urandom_range(0, 9) < 7);
      if (need_new) begin
        if32.in_valid = ($urandom_range(0, 9) < 8);
        rand32();
      end
      @(negedge clk);
      need_new = !(if32.in_valid && !if32.in_ready);
      if (if32.in_valid && if32.in_ready) sent++;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("rand_sent", 64'(sent), 64'd10000);
    if32.in_valid = 1'b0;
    if32.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("drain32", 64'(q32.size()), 64'd0);
    chk("drain16", 64'(q16.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
